// File: rtl/reduce_pkg.sv
// reduce_pkg
// Shared constants and elaboration-time helpers for the reduce_pipe reduction
// tree. Pipeline depth, popcount width and level width are computed here so
// the top and its stages derive their geometry the same way.
package reduce_pkg;

  // Values that leave each reduction unchanged; used for masked-off bits.
  localparam logic AND_NEUTRAL = 1'b1;
  localparam logic OR_NEUTRAL  = 1'b0;
  localparam logic XOR_NEUTRAL = 1'b0;

  // Pipeline depth: one tree level per stage, at least one stage.
  function automatic int lat_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold a popcount of n bits.
  function automatic int cnt_w_f(input int n);
    return $clog2(n + 1);
  endfunction

  // Element count after one pairwise level; an odd tail passes through.
  function automatic int half_f(input int n);
    return (n + 1) / 2;
  endfunction

  // Element count entering tree level k when level 0 holds n elements.
  function automatic int lvl_n_f(input int n, input int k);
    int r;
    r = n;
    for (int i = 0; i < k; i++) begin
      r = half_f(r);
    end
    return r;
  endfunction

  function automatic int min_f(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// reduce_stage
// One level of the reduction tree: combines adjacent element pairs of the
// previous level (odd tail passes through) and registers the result together
// with a valid bit. All registers advance only when en is high, so a stalled
// pipeline holds bubbles and data in place.
// Optional feature: REDUCE_CNT_EN adds a popcount lane (i_cnt/o_cnt) whose
// element width grows from CNT_W_IN to CNT_W.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                global advance enable
//   i_valid/o_valid   stage valid in / registered valid out
//   i_and/i_or/i_xor  N_LVL_IN partial reductions from the previous level
//   o_and/o_or/o_xor  half_f(N_LVL_IN) registered partial reductions
//   i_cnt/o_cnt       packed partial popcounts (REDUCE_CNT_EN only)
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int N_LVL_IN = 2,
  parameter int CNT_W_IN = 1,
  parameter int CNT_W    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          i_valid,
  input  logic [N_LVL_IN-1:0]           i_and,
  input  logic [N_LVL_IN-1:0]           i_or,
  input  logic [N_LVL_IN-1:0]           i_xor,
`ifdef REDUCE_CNT_EN
  input  logic [N_LVL_IN*CNT_W_IN-1:0]  i_cnt,
  output logic [half_f(N_LVL_IN)*CNT_W-1:0] o_cnt,
`endif
  output logic                          o_valid,
  output logic [half_f(N_LVL_IN)-1:0]   o_and,
  output logic [half_f(N_LVL_IN)-1:0]   o_or,
  output logic [half_f(N_LVL_IN)-1:0]   o_xor
);

  localparam int N_OUT = half_f(N_LVL_IN);

  logic [N_OUT-1:0] w_and;
  logic [N_OUT-1:0] w_or;
  logic [N_OUT-1:0] w_xor;
  logic             r_valid;
  logic [N_OUT-1:0] r_and;
  logic [N_OUT-1:0] r_or;
  logic [N_OUT-1:0] r_xor;
`ifdef REDUCE_CNT_EN
  logic [N_OUT*CNT_W-1:0] w_cnt;
  logic [N_OUT*CNT_W-1:0] r_cnt;
`endif

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    if (2 * j + 1 < N_LVL_IN) begin : g_two
      assign w_and[j] = i_and[2*j] & i_and[2*j+1];
      assign w_or[j]  = i_or[2*j]  | i_or[2*j+1];
      assign w_xor[j] = i_xor[2*j] ^ i_xor[2*j+1];
`ifdef REDUCE_CNT_EN
      // Operands widened before the add so the carry lands in the new top bit.
      assign w_cnt[j*CNT_W +: CNT_W] = CNT_W'(i_cnt[2*j*CNT_W_IN +: CNT_W_IN])
                                     + CNT_W'(i_cnt[(2*j+1)*CNT_W_IN +: CNT_W_IN]);
`endif
    end else begin : g_one
      assign w_and[j] = i_and[2*j];
      assign w_or[j]  = i_or[2*j];
      assign w_xor[j] = i_xor[2*j];
`ifdef REDUCE_CNT_EN
      assign w_cnt[j*CNT_W +: CNT_W] = CNT_W'(i_cnt[2*j*CNT_W_IN +: CNT_W_IN]);
`endif
    end
  end

  // Level registers: invalid slots shift like valid ones, everything holds on !en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_and   <= '0;
      r_or    <= '0;
      r_xor   <= '0;
`ifdef REDUCE_CNT_EN
      r_cnt   <= '0;
`endif
    end else if (en) begin
      r_valid <= i_valid;
      r_and   <= w_and;
      r_or    <= w_or;
      r_xor   <= w_xor;
`ifdef REDUCE_CNT_EN
      r_cnt   <= w_cnt;
`endif
    end
  end

  assign o_valid = r_valid;
  assign o_and   = r_and;
  assign o_or    = r_or;
  assign o_xor   = r_xor;
`ifdef REDUCE_CNT_EN
  assign o_cnt   = r_cnt;
`endif

endmodule

// File: rtl/reduce_pipe.sv
// reduce_pipe
// Pipelined AND/OR/XOR reduction of a masked N_IN-bit vector with valid/ready
// handshakes on both sides. A masked-off bit is replaced by the neutral value
// of each reduction, so an all-zero mask yields and=1, or=0, xor=0. Results
// appear LAT = max(1, clog2(N_IN)) cycles after acceptance; the whole pipe
// advances together (en = !out_valid || out_ready), so a stall freezes every
// stage including bubbles.
// Optional feature: define REDUCE_CNT_EN to add out_cnt, the popcount of the
// participating bits; without it the port and all count logic are absent.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_vec, in_mask       operand bits and participation mask
//   out_valid / out_ready output handshake
//   out_and/or/xor        registered reduction results
//   out_cnt               registered popcount (REDUCE_CNT_EN only)
module reduce_pipe
  import reduce_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  input  logic [N_IN-1:0] in_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_and,
  output logic            out_or,
  output logic            out_xor
`ifdef REDUCE_CNT_EN
  ,
  output logic [cnt_w_f(N_IN)-1:0] out_cnt
`endif
);

  localparam int LAT = lat_f(N_IN);
  localparam int CW  = cnt_w_f(N_IN);

  logic            w_en;
  logic            w_acc;
  logic [N_IN-1:0] w_m_and;
  logic [N_IN-1:0] w_m_or;
  logic [N_IN-1:0] w_m_xor;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_acc    = in_valid && w_en;

  // Mask stage: non-participating bits become the neutral element of each lane.
  for (genvar b = 0; b < N_IN; b++) begin : g_mask
    assign w_m_and[b] = in_mask[b] ? in_vec[b] : AND_NEUTRAL;
    assign w_m_or[b]  = in_mask[b] ? in_vec[b] : OR_NEUTRAL;
    assign w_m_xor[b] = in_mask[b] ? in_vec[b] : XOR_NEUTRAL;
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stg
    localparam int NI = lvl_n_f(N_IN, k);
    localparam int NO = lvl_n_f(N_IN, k + 1);
    // Count elements grow one bit per level, capped at the final width.
    localparam int CI = min_f(k + 1, CW);
    localparam int CO = min_f(k + 2, CW);

    logic          w_vld_i;
    logic [NI-1:0] w_and_i;
    logic [NI-1:0] w_or_i;
    logic [NI-1:0] w_xor_i;
    logic          w_vld_o;
    logic [NO-1:0] w_and_o;
    logic [NO-1:0] w_or_o;
    logic [NO-1:0] w_xor_o;
`ifdef REDUCE_CNT_EN
    logic [NI*CI-1:0] w_cnt_i;
    logic [NO*CO-1:0] w_cnt_o;
`endif

    if (k == 0) begin : g_first
      assign w_vld_i = w_acc;
      assign w_and_i = w_m_and;
      assign w_or_i  = w_m_or;
      assign w_xor_i = w_m_xor;
`ifdef REDUCE_CNT_EN
      // A masked bit contributes its own value (0 when masked) as a 1-bit count.
      assign w_cnt_i = w_m_or;
`endif
    end else begin : g_next
      assign w_vld_i = g_stg[k-1].w_vld_o;
      assign w_and_i = g_stg[k-1].w_and_o;
      assign w_or_i  = g_stg[k-1].w_or_o;
      assign w_xor_i = g_stg[k-1].w_xor_o;
`ifdef REDUCE_CNT_EN
      assign w_cnt_i = g_stg[k-1].w_cnt_o;
`endif
    end

    reduce_stage #(
      .N_LVL_IN (NI),
      .CNT_W_IN (CI),
      .CNT_W    (CO)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (w_en),
      .i_valid (w_vld_i),
      .i_and   (w_and_i),
      .i_or    (w_or_i),
      .i_xor   (w_xor_i),
`ifdef REDUCE_CNT_EN
      .i_cnt   (w_cnt_i),
      .o_cnt   (w_cnt_o),
`endif
      .o_valid (w_vld_o),
      .o_and   (w_and_o),
      .o_or    (w_or_o),
      .o_xor   (w_xor_o)
    );
  end

  // The last level has exactly one element, so its registers are the outputs.
  assign out_valid = g_stg[LAT-1].w_vld_o;
  assign out_and   = g_stg[LAT-1].w_and_o;
  assign out_or    = g_stg[LAT-1].w_or_o;
  assign out_xor   = g_stg[LAT-1].w_xor_o;
`ifdef REDUCE_CNT_EN
  assign out_cnt   = g_stg[LAT-1].w_cnt_o;
`endif

endmodule

// File: tb/tb_reduce_pipe.sv
// Bench for reduce_pipe: three instances (N_IN = 4, 5, 1) with a
// queue-based scoreboard per instance. Count checks are active only when the
// design is built with REDUCE_CNT_EN.
module tb_reduce_pipe;

  typedef struct packed {
    logic       a;
    logic       o;
    logic       x;
    logic [2:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // N_IN = 4 instance
  logic       in_valid, in_ready, out_valid, out_ready, out_and, out_or, out_xor;
  logic [3:0] in_vec, in_mask;
  exp_t       expq[$];
`ifdef REDUCE_CNT_EN
  logic [2:0] out_cnt;
`endif

  // N_IN = 5 instance
  logic       v5_in_valid, v5_in_ready, v5_out_valid, v5_out_ready, v5_and, v5_or, v5_xor;
  logic [4:0] v5_vec, v5_mask;
  exp_t       q5[$];
`ifdef REDUCE_CNT_EN
  logic [2:0] v5_cnt;
`endif

  // N_IN = 1 instance
  logic       v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready, v1_and, v1_or, v1_xor;
  logic [0:0] v1_vec, v1_mask;
  exp_t       q1[$];
`ifdef REDUCE_CNT_EN
  logic [0:0] v1_cnt;
`endif

  reduce_pipe #(.N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_and(out_and), .out_or(out_or), .out_xor(out_xor)
`ifdef REDUCE_CNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  reduce_pipe #(.N_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5_in_valid), .in_ready(v5_in_ready),
    .in_vec(v5_vec), .in_mask(v5_mask), .out_valid(v5_out_valid), .out_ready(v5_out_ready),
    .out_and(v5_and), .out_or(v5_or), .out_xor(v5_xor)
`ifdef REDUCE_CNT_EN
    , .out_cnt(v5_cnt)
`endif
  );

  reduce_pipe #(.N_IN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .in_vec(v1_vec), .in_mask(v1_mask), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
    .out_and(v1_and), .out_or(v1_or), .out_xor(v1_xor)
`ifdef REDUCE_CNT_EN
    , .out_cnt(v1_cnt)
`endif
  );

  // Bit-serial reference for the 4-bit instance.
  function automatic exp_t model4(input logic [3:0] v, input logic [3:0] m);
    exp_t e;
    e.a = 1'b1; e.o = 1'b0; e.x = 1'b0; e.c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        e.a = e.a & v[i];
        e.o = e.o | v[i];
        e.x = e.x ^ v[i];
        e.c = e.c + 3'(v[i]);
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    in_valid = 1'b0; in_vec = 4'd0; in_mask = 4'd0; out_ready = 1'b1;
    v5_in_valid = 1'b0; v5_vec = 5'd0; v5_mask = 5'd0; v5_out_ready = 1'b1;
    v1_in_valid = 1'b0; v1_vec = 1'b0; v1_mask = 1'b0; v1_out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_tests++; if ({out_and, out_or, out_xor} !== 3'b000) begin n_fail++; $display("FAIL rst_outs got %b exp 000", {out_and, out_or, out_xor}); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
`ifdef REDUCE_CNT_EN
    n_tests++; if (out_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", out_cnt); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask

  // Single vector into an idle pipe: checks latency and result.
  task automatic test_basic(input logic [3:0] v, input logic [3:0] m, input string nm);
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    in_vec = v; in_mask = m; in_valid = 1'b1; out_ready = 1'b1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready got %b exp 1", nm, in_ready); end
    expq.push_back(model4(v, m));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL %s_lat got %0d exp 2", nm, lat); end
    e = expq.pop_front();
    n_tests++; if ({out_and, out_or, out_xor} !== {e.a, e.o, e.x}) begin
      n_fail++; $display("FAIL %s_aox got %b exp %b", nm, {out_and, out_or, out_xor}, {e.a, e.o, e.x});
    end
`ifdef REDUCE_CNT_EN
    n_tests++; if (out_cnt !== e.c) begin n_fail++; $display("FAIL %s_cnt got %0d exp %0d", nm, out_cnt, e.c); end
`endif
  endtask

  // Eight vectors streamed, consumer stalls in cycles 3..5.
  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] snap;
    int sent = 0;
    int got  = 0;
    logic [3:0] vv, mm;
    @(posedge clk); #1;
    for (int c = 0; c < 60 && (sent < 8 || expq.size() > 0); c++) begin
      out_ready = !(c >= 3 && c <= 5);
      vv = 4'(sent * 5 + 3);
      mm = 4'(sent * 7 + 9);
      in_valid = (sent < 8);
      in_vec = vv; in_mask = mm;
      @(negedge clk);
      if (c <= 8) begin
        n_tests++; if (in_ready !== !(c >= 3 && c <= 5)) begin
          n_fail++; $display("FAIL b2b_in_ready c=%0d got %b exp %b", c, in_ready, !(c >= 3 && c <= 5));
        end
      end
      if (c == 3) snap = {out_valid, out_and, out_or, out_xor, 2'b00};
`ifdef REDUCE_CNT_EN
      if (c == 3) snap[1:0] = out_cnt[1:0];
`endif
      if (c == 4 || c == 5) begin
        n_tests++;
`ifdef REDUCE_CNT_EN
        if ({out_valid, out_and, out_or, out_xor, out_cnt[1:0]} !== snap) begin
          n_fail++; $display("FAIL b2b_stall_hold c=%0d got %b exp %b", c, {out_valid, out_and, out_or, out_xor, out_cnt[1:0]}, snap);
        end
`else
        if ({out_valid, out_and, out_or, out_xor, 2'b00} !== snap) begin
          n_fail++; $display("FAIL b2b_stall_hold c=%0d got %b exp %b", c, {out_valid, out_and, out_or, out_xor}, snap[5:2]);
        end
`endif
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (expq.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL b2b_extra_result c=%0d got 1 exp 0", c);
        end else begin
          e = expq.pop_front();
          got++;
          n_tests++; if ({out_and, out_or, out_xor} !== {e.a, e.o, e.x}) begin
            n_fail++; $display("FAIL b2b_aox_%0d got %b exp %b", got, {out_and, out_or, out_xor}, {e.a, e.o, e.x});
          end
`ifdef REDUCE_CNT_EN
          n_tests++; if (out_cnt !== e.c) begin n_fail++; $display("FAIL b2b_cnt_%0d got %0d exp %0d", got, out_cnt, e.c); end
`endif
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        expq.push_back(model4(vv, mm));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (got != 8 || sent != 8) begin n_fail++; $display("FAIL b2b_count got %0d/%0d exp 8/8", got, sent); end
    expq.delete();
  endtask

  // Reset asserted with two results in flight.
  task automatic test_reset_mid();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'b1111; in_mask = 4'b1111;
    @(posedge clk); #1;
    in_vec = 4'b0110; in_mask = 4'b0111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got %b exp 1", out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    n_tests++; if ({out_and, out_or, out_xor} !== 3'b000) begin n_fail++; $display("FAIL rmid_outs got %b exp 000", {out_and, out_or, out_xor}); end
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale got %b exp 0", out_valid); end
    end
    test_basic(4'b0011, 4'b1110, "post_rst");
  endtask

  // Padded width: N_IN = 5, LAT = 3.
  task automatic test_pad5();
    logic [4:0] vs[3] = '{5'b10000, 5'b01111, 5'b11111};
    logic [4:0] ms[3] = '{5'b11111, 5'b10111, 5'b00000};
    exp_t es[3] = '{'{1'b0, 1'b1, 1'b1, 3'd1}, '{1'b0, 1'b1, 1'b1, 3'd3}, '{1'b1, 1'b0, 1'b0, 3'd0}};
    exp_t e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      v5_vec = vs[i]; v5_mask = ms[i]; v5_in_valid = 1'b1;
      q5.push_back(es[i]);
      @(posedge clk); #1;
      v5_in_valid = 1'b0;
      lat = 1;
      while (v5_out_valid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
      n_tests++; if (lat != 3) begin n_fail++; $display("FAIL n5_lat_%0d got %0d exp 3", i, lat); end
      e = q5.pop_front();
      n_tests++; if ({v5_and, v5_or, v5_xor} !== {e.a, e.o, e.x}) begin
        n_fail++; $display("FAIL n5_aox_%0d got %b exp %b", i, {v5_and, v5_or, v5_xor}, {e.a, e.o, e.x});
      end
`ifdef REDUCE_CNT_EN
      n_tests++; if (v5_cnt !== e.c) begin n_fail++; $display("FAIL n5_cnt_%0d got %0d exp %0d", i, v5_cnt, e.c); end
`endif
    end
  endtask

  // Single-bit instance: LAT = 1.
  task automatic test_n1();
    logic vs[3] = '{1'b0, 1'b1, 1'b0};
    logic ms[3] = '{1'b0, 1'b1, 1'b1};
    exp_t es[3] = '{'{1'b1, 1'b0, 1'b0, 3'd0}, '{1'b1, 1'b1, 1'b1, 3'd1}, '{1'b0, 1'b0, 1'b0, 3'd0}};
    exp_t e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      v1_vec = vs[i]; v1_mask = ms[i]; v1_in_valid = 1'b1;
      q1.push_back(es[i]);
      @(posedge clk); #1;
      v1_in_valid = 1'b0;
      lat = 1;
      while (v1_out_valid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL n1_lat_%0d got %0d exp 1", i, lat); end
      e = q1.pop_front();
      n_tests++; if ({v1_and, v1_or, v1_xor} !== {e.a, e.o, e.x}) begin
        n_fail++; $display("FAIL n1_aox_%0d got %b exp %b", i, {v1_and, v1_or, v1_xor}, {e.a, e.o, e.x});
      end
`ifdef REDUCE_CNT_EN
      n_tests++; if (v1_cnt !== e.c[0]) begin n_fail++; $display("FAIL n1_cnt_%0d got %0d exp %0d", i, v1_cnt, e.c[0]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic(4'b1111, 4'b1111, "all_ones");
    test_basic(4'b0110, 4'b0111, "partial_mask");
    test_basic(4'b0110, 4'b0000, "mask_zero");
    test_basic(4'b1010, 4'b1011, "odd_xor");
    test_back_to_back();
    test_reset_mid();
    test_pad5();
    test_n1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
